// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - b_in, one bit per clock,
// LSB first, through a single full-subtractor cell and a borrow flip-flop.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] aSr_q,    aSr_d;
    logic [WIDTH-1:0] bSr_q,    bSr_d;
    logic [WIDTH-1:0] resSr_q,  resSr_d;
    logic             brw_q,    brw_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             bOut_q,   bOut_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic             bitDiff;
    logic             bitBorrow;
    logic [WIDTH-1:0] resShifted;
    logic             lastBit;

    // The single full-subtractor cell working on the current LSBs.
    always_comb begin
        bitDiff    = aSr_q[0] ^ bSr_q[0] ^ brw_q;
        bitBorrow  = (~aSr_q[0] & bSr_q[0]) | (~(aSr_q[0] ^ bSr_q[0]) & brw_q);
        resShifted = {bitDiff, resSr_q[WIDTH-1:1]};
        lastBit    = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_comb begin
        state_d = state_q;
        aSr_d   = aSr_q;
        bSr_d   = bSr_q;
        resSr_d = resSr_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bOut_d  = bOut_q;
        busy_d  = busy_q;
        done_d  = done_q;

        case (state_q)
            ST_IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    aSr_d   = a;
                    bSr_d   = b;
                    brw_d   = b_in;
                    resSr_d = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                aSr_d   = aSr_q >> 1;
                bSr_d   = bSr_q >> 1;
                brw_d   = bitBorrow;
                resSr_d = resShifted;
                cnt_d   = cnt_q + CNT_W'(1);
                // The result registers only move here, so the previous answer
                // stays visible for the whole duration of a new computation.
                if (lastBit) begin
                    diff_d  = resShifted;
                    bOut_d  = bitBorrow;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_FINISH;
                end
            end

            ST_FINISH: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            aSr_q   <= '0;
            bSr_q   <= '0;
            resSr_q <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bOut_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            aSr_q   <= aSr_d;
            bSr_q   <= bSr_d;
            resSr_q <= resSr_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bOut_q  <= bOut_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign diff  = diff_q;
    assign b_out = bOut_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): a queue of expected
// {b_out, diff} values is filled when operations are launched and drained on done.
module tb_serial_subtractor;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             b_out;

    int errors = 0;
    int checks = 0;

    logic [WIDTH:0] sb[$];
    logic [WIDTH-1:0] lastDiff;
    logic             lastBout;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .b_out  (b_out)
    );

    // Reference arithmetic: borrow out whenever the exact difference is negative.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] aV,
                                             input logic [WIDTH-1:0] bV,
                                             input logic binV);
        int t;
        logic [WIDTH:0] r;
        t = int'(aV) - int'(bV) - int'(binV);
        r[WIDTH-1:0] = t[WIDTH-1:0];
        r[WIDTH]     = (t < 0);
        return r;
    endfunction

    task automatic takeExpected(output logic [WIDTH:0] e);
        if (sb.size() == 0) e = 'x;
        else                e = sb.pop_front();
    endtask

    // Raises start for exactly one rising edge; returns just after that edge.
    task automatic launchOp(input logic [WIDTH-1:0] aV, input logic [WIDTH-1:0] bV,
                            input logic binV);
        @(posedge clk); #1;
        a = aV; b = bV; b_in = binV; start = 1'b1;
        sb.push_back(model(aV, bV, binV));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // k counts rising edges after the accepting edge at the sampling point.
    task automatic waitForDone(input int budget, output int k, output bit seen);
        k = 0;
        @(negedge clk);
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        seen = (done === 1'b1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, b_out, diff} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b b_out=%b diff=%0d, want all 0",
                     busy, done, b_out, diff);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle: got busy=%b done=%b, want 0/0", busy, done);
        end
        lastDiff = '0; lastBout = 1'b0;
    endtask

    task automatic test_borrow_wrap();
        logic [WIDTH:0] e;
        launchOp(4'd0, 4'd0, 1'b1);
        for (int k = 0; k < WIDTH; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL wrap_busy[%0d]: got busy=%b done=%b, want 1/0", k, busy, done);
            end
        end
        @(negedge clk);
        takeExpected(e);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || {b_out, diff} !== e) begin
            errors++;
            $display("[TB] FAIL wrap_result: got done=%b busy=%b b_out=%b diff=%0d, want 1/0 b_out=%b diff=%0d",
                     done, busy, b_out, diff, e[WIDTH], e[WIDTH-1:0]);
        end
        lastDiff = e[WIDTH-1:0]; lastBout = e[WIDTH];
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_done_width: got done=%b, want 0", done);
        end
    endtask

    task automatic test_sequence();
        logic [WIDTH-1:0] av[3] = '{4'd1, 4'd8, 4'd15};
        logic [WIDTH-1:0] bv[3] = '{4'd1, 4'd0, 4'd1};
        logic             iv[3] = '{1'b0, 1'b1, 1'b0};
        logic [WIDTH:0]   e;
        int  k;
        bit  seen;
        for (int i = 0; i < 3; i++) begin
            launchOp(av[i], bv[i], iv[i]);
            waitForDone(12, k, seen);
            checks++;
            if (!seen || k != WIDTH) begin
                errors++;
                $display("[TB] FAIL seq_latency[%0d]: got seen=%0b edges=%0d, want 1 edges=%0d", i, seen, k, WIDTH);
            end
            takeExpected(e);
            checks++;
            if ({b_out, diff} !== e) begin
                errors++;
                $display("[TB] FAIL seq_result[%0d]: got b_out=%b diff=%0d, want b_out=%b diff=%0d",
                         i, b_out, diff, e[WIDTH], e[WIDTH-1:0]);
            end
            lastDiff = e[WIDTH-1:0]; lastBout = e[WIDTH];
        end
    endtask

    task automatic test_operand_change();
        logic [WIDTH:0] e;
        int k;
        bit seen;
        launchOp(4'd2, 4'd15, 1'b1);
        a = 4'd9; b = 4'd9; b_in = 1'b0;
        waitForDone(12, k, seen);
        takeExpected(e);
        checks++;
        if (!seen || k != WIDTH || {b_out, diff} !== e) begin
            errors++;
            $display("[TB] FAIL operand_change: got seen=%0b edges=%0d b_out=%b diff=%0d, want edges=%0d b_out=%b diff=%0d",
                     seen, k, b_out, diff, WIDTH, e[WIDTH], e[WIDTH-1:0]);
        end
        lastDiff = e[WIDTH-1:0]; lastBout = e[WIDTH];
    endtask

    task automatic test_ignored_start();
        logic [WIDTH:0] e;
        int doneCount = 0;
        int doneK = -1;
        launchOp(4'd5, 4'd3, 1'b0);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                doneCount++;
                doneK = k;
                takeExpected(e);
                checks++;
                if ({b_out, diff} !== e) begin
                    errors++;
                    $display("[TB] FAIL ignored_result: got b_out=%b diff=%0d, want b_out=%b diff=%0d",
                             b_out, diff, e[WIDTH], e[WIDTH-1:0]);
                end
                lastDiff = e[WIDTH-1:0]; lastBout = e[WIDTH];
            end else if (doneCount == 0) begin
                checks++;
                if (diff !== lastDiff || b_out !== lastBout) begin
                    errors++;
                    $display("[TB] FAIL ignored_hold[%0d]: got b_out=%b diff=%0d, want b_out=%b diff=%0d",
                             k, b_out, diff, lastBout, lastDiff);
                end
            end
            if (k == 1) begin
                start = 1'b1; a = 4'd0; b = 4'd1;
            end else begin
                start = 1'b0;
            end
        end
        checks++;
        if (doneCount != 1 || doneK != WIDTH) begin
            errors++;
            $display("[TB] FAIL ignored_pulses: got count=%0d at=%0d, want count=1 at=%0d", doneCount, doneK, WIDTH);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH:0] e;
        int  doneCount = 0;
        int  lastCyc   = -1;
        bit  prevDone  = 1'b0;
        a = 4'd0; b = 4'd15; b_in = 1'b0; start = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back(model(4'd0, 4'd15, 1'b0));
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                doneCount++;
                takeExpected(e);
                checks++;
                if ({b_out, diff} !== e) begin
                    errors++;
                    $display("[TB] FAIL b2b_result[%0d]: got b_out=%b diff=%0d, want b_out=%b diff=%0d",
                             cyc, b_out, diff, e[WIDTH], e[WIDTH-1:0]);
                end
                checks++;
                if ((lastCyc < 0 && cyc != WIDTH) || (lastCyc >= 0 && cyc - lastCyc != WIDTH + 2) || prevDone) begin
                    errors++;
                    $display("[TB] FAIL b2b_spacing[%0d]: got prev=%0d consecutive=%0b, want spacing %0d",
                             cyc, lastCyc, prevDone, WIDTH + 2);
                end
                lastCyc = cyc;
            end
            prevDone = (done === 1'b1);
            if (cyc == 19) start = 1'b0;
        end
        checks++;
        if (doneCount != 4 || sb.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_count: got pulses=%0d left=%0d busy=%b, want 4/0/0", doneCount, sb.size(), busy);
        end
        lastDiff = 4'd1; lastBout = 1'b1;
    endtask

    task automatic test_reset_mid_op();
        logic [WIDTH:0] e;
        int k;
        bit seen;
        launchOp(4'd3, 4'd1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1 reset_n = 1'b0;
        sb.delete();
        #1;
        checks++;
        if ({busy, done, b_out, diff} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL midreset_clear: got busy=%b done=%b b_out=%b diff=%0d, want all 0",
                     busy, done, b_out, diff);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || diff !== 4'd0) begin
                errors++;
                $display("[TB] FAIL midreset_idle[%0d]: got busy=%b done=%b diff=%0d, want 0/0/0", i, busy, done, diff);
            end
        end
        launchOp(4'd15, 4'd0, 1'b0);
        waitForDone(12, k, seen);
        takeExpected(e);
        checks++;
        if (!seen || k != WIDTH || {b_out, diff} !== e) begin
            errors++;
            $display("[TB] FAIL midreset_fresh: got seen=%0b edges=%0d b_out=%b diff=%0d, want edges=%0d b_out=%b diff=%0d",
                     seen, k, b_out, diff, WIDTH, e[WIDTH], e[WIDTH-1:0]);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] serial_subtractor bench starting");
        test_reset();
        test_borrow_wrap();
        test_sequence();
        test_operand_change();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial ripple-borrow subtractor: computes diff = a - b - b_in, one bit per clock, LSB first, using a single full-subtractor cell plus a borrow flip-flop.
- Sequential counterpart to the combinational ripple-carry adder datapath. Serves the multi-cycle ALU path where area matters more than latency.
- Start/busy/done handshake; the result is held until the next accepted start.

Parameters:
- WIDTH, 4, operand and result width in bits (>= 2)

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when in IDLE
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- b_in  input  1  borrow-in; captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  result, modulo 2^WIDTH
- b_out  output  1  final borrow; 1 when a < b + b_in (unsigned)

Behaviour:
- Reset: while reset_n = 0, asynchronously force state=IDLE, busy=0, done=0, diff=0, b_out=0, and clear all internal registers (operand shift regs, borrow FF, bit counter).
- States: IDLE, SHIFT, FINISH.
- IDLE, start=1 at edge E0:
  - load a_sr<=a, b_sr<=b, brw<=b_in, cnt<=0
  - go to SHIFT; busy=1 from E0.
- SHIFT, each edge:
  - d = a_sr[0] ^ b_sr[0] ^ brw
  - brw <= (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw)
  - a_sr and b_sr shift right by 1; d shifts into the MSB of internal res_sr
  - cnt increments.
- SHIFT to FINISH: on the edge that processes bit WIDTH-1 (the WIDTH-th shift edge, EWIDTH). On that edge:
  - diff <= final res_sr; b_out <= final borrow
  - done <= 1; busy <= 0.
- FINISH: lasts one cycle; done=1 and busy=0. At the next edge, done <= 0 and the state returns to IDLE.
- Latency: start sampled at E0 -> done high for exactly one cycle after edge EWIDTH. Result is valid from EWIDTH onward.
- Throughput: at most one operation per WIDTH+2 cycles.
- start while busy=1 or in FINISH: ignored. Operands are not re-captured and the current operation is not disturbed.
- start held high continuously: a new operation is accepted on the first edge in IDLE. done therefore pulses once per operation; done is never high for two consecutive cycles.
- diff/b_out hold the previous result throughout a new computation. They change only on the completion edge.
- a, b, b_in may change freely after the start edge without affecting the result.
- Reset asserted mid-operation: the operation is aborted immediately, with no done pulse and outputs cleared as in the reset state. After release, the block waits in IDLE for a new start.
- Arithmetic: unsigned modulo 2^WIDTH. {b_out, diff} equals the two's-complement-style result, i.e. diff = (a - b - b_in) mod 2^WIDTH.
- Single clock domain; no combinational path from inputs to outputs.

Test Plan (WIDTH=4):
- a=0, b=0, b_in=1, start one cycle -> busy for 4 cycles, then done pulse with diff=15, b_out=1.
- Sequence a=1,b=1,b_in=0 / a=8,b=0,b_in=1 / a=15,b=1,b_in=0 -> diff=0,b_out=0 / diff=7,b_out=0 / diff=14,b_out=0. done rises exactly 4 edges after each accepted start.
- a=2, b=15, b_in=1 -> diff=2, b_out=1. Change a/b to 9/9 one cycle after start -> result still 2/1.
- Accepted start with a=5,b=3, then pulse start with a=0,b=1 during busy -> ignored. Only one done pulse, with diff=2, b_out=0. The prior diff holds until that done.
- start held high for 20 cycles with a=0, b=15, b_in=0 -> done pulses every 6 cycles, each with diff=1, b_out=1.
- reset_n low 2 cycles into an operation -> busy, done, diff and b_out go 0 immediately, with no done pulse. A fresh start with a=15,b=0,b_in=0 -> diff=15, b_out=0.
